data_bus_arbiter: RTL and testbench
===================================

DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of the requester and bus address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of the write and read data.
REQ-003 SHALL have parameter TIMEOUT, default 255, the maximum number of WAIT cycles before an access is aborted (range 1..255).
REQ-004 SHALL have ports clk (input, 1) and rst (input, 1): one clock; reset is synchronous and active-high.
REQ-005 SHALL have per requester k in {0,1}: mk_req (in, 1) access request; mk_w (in, 1) 1=write, 0=read; mk_size (in, 2) 00=byte, 01=half, 10=word; mk_addr (in, ADDR_WIDTH); mk_wdata (in, DATA_WIDTH).
REQ-006 SHALL have per requester: mk_gnt (out, 1) granted; mk_done (out, 1) one-cycle completion pulse; mk_err (out, 1) one-cycle timeout pulse; mk_rdata (out, DATA_WIDTH) read data.
REQ-007 SHALL have bus-side ports: bus_wd (out, 1), bus_rd (out, 1), bus_size (out, 2), bus_addr (out, ADDR_WIDTH), bus_wdata (out, DATA_WIDTH), bus_rdata (in, DATA_WIDTH), bus_ready (in, 1), bus_busy (in, 1).
REQ-008 SHALL have port busy (out, 1), high in every state except IDLE.

Function
REQ-009 SHALL implement the FSM states IDLE, ISSUE, WAIT and DONE, with exactly one state active per cycle.
REQ-010 IDLE: when (m0_req | m1_req) & bus_ready, the FSM SHALL select a winner, capture its w/size/addr/wdata into holding registers, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-011 Arbitration: a single request SHALL win; on simultaneous requests the requester not recorded in last_grant SHALL win (round-robin).
REQ-012 SHALL update last_grant to the winner on entry to DONE.
REQ-013 mk_gnt SHALL be high for the winner from the ISSUE cycle through the DONE cycle inclusive, and never high for both requesters at once.
REQ-014 ISSUE: SHALL assert bus_wd (captured w=1) or bus_rd (captured w=0) for exactly one cycle, then go to WAIT.
REQ-015 bus_addr, bus_size and bus_wdata SHALL present the captured values from ISSUE through DONE, and SHALL be zero in IDLE.
REQ-016 WAIT: when bus_busy=0 the FSM SHALL go to DONE and latch bus_rdata (reads only); otherwise it SHALL increment the 8-bit wait counter.
REQ-017 When the wait counter equals TIMEOUT with bus_busy=1, the FSM SHALL go to DONE with an error flag set and SHALL leave the read data unchanged.
REQ-018 DONE: SHALL pulse mk_done for exactly one cycle for the winner, plus mk_err if the error flag is set; it SHALL clear the counter and the flag, and go to IDLE.
REQ-019 mk_rdata SHALL hold the last read result for that requester until its next successful read completes.
REQ-020 Minimum latency: req sampled in IDLE at cycle N -> gnt and strobe at N+1 -> WAIT at N+2 -> done at N+3 when bus_busy=0 at N+2.
REQ-021 Changes to mk_req or mk_addr after capture SHALL NOT affect an access in progress, and a dropped request SHALL still complete.
REQ-022 A requester holding mk_req through its done cycle SHALL be re-arbitrated in the following IDLE cycle, so back-to-back accesses have one idle gap.
REQ-023 While bus_ready=0 in IDLE, requests SHALL stay pending with no grant.

Reset
REQ-024 With rst=1 at a clock edge, the FSM SHALL go to IDLE from any state, including mid-access.
REQ-025 Reset SHALL set: all gnt/done/err/bus_wd/bus_rd/busy=0; bus_addr/bus_wdata/bus_size=0; mk_rdata=0; counter=0; last_grant=1, so m0 wins the first tie.
REQ-026 An access interrupted by reset SHALL produce no done or err pulse.

Verification
REQ-027 Single read: m0 read, addr=0x100, bus_busy=0 -> bus_rd one cycle at N+1, bus_addr=0x100, bus_rdata=0xDEADBEEF, m0_done and m0_rdata=0xDEADBEEF at N+3.
REQ-028 Tie: m0 and m1 request together after reset -> m0 granted first; m1 granted in the IDLE cycle after m0_done; then a further tie grants m0.
REQ-029 Wait states: m1 write, addr=0x40, wdata=0x12345678, size=10, bus_busy high 4 cycles -> bus_wd one cycle, m1_done 5 cycles after ISSUE, m1_rdata unchanged.
REQ-030 Timeout: TIMEOUT=8, bus_busy stuck high -> exactly 8 WAIT cycles, then m0_err and m0_done pulse together, busy=0 one cycle later.
REQ-031 Reset mid-WAIT: rst=1 during WAIT -> next cycle IDLE, gnt=0, no done pulse, last_grant=1.
REQ-032 bus_ready=0 with m0_req=1 for 5 cycles -> no gnt or strobe; bus_ready=1 -> gnt next cycle.

Source files
------------

// File: rtl/data_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single strobe/busy bus,
// with wait-state counting and abort of accesses that stay busy too long.
module data_bus_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_req,
   input  logic                  m0_w,
   input  logic [1:0]            m0_size,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_gnt,
   output logic                  m0_done,
   output logic                  m0_err,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_w,
   input  logic [1:0]            m1_size,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_gnt,
   output logic                  m1_done,
   output logic                  m1_err,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  bus_wd,
   output logic                  bus_rd,
   output logic [1:0]            bus_size,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic [DATA_WIDTH-1:0] bus_rdata,
   input  logic                  bus_ready,
   input  logic                  bus_busy,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t                state;
   logic                  last_grant;
   logic                  win;
   logic                  hold_w;
   logic [7:0]            wait_cnt;
   logic [7:0]            wait_cnt_nxt;
   logic                  pick;
   logic                  cap_w;
   logic [1:0]            cap_size;
   logic [ADDR_WIDTH-1:0] cap_addr;
   logic [DATA_WIDTH-1:0] cap_wdata;

   // On a tie the requester that did not win last time gets the bus.
   assign pick         = (m0_req && m1_req) ? ~last_grant : m1_req;
   assign cap_w        = pick ? m1_w     : m0_w;
   assign cap_size     = pick ? m1_size  : m0_size;
   assign cap_addr     = pick ? m1_addr  : m0_addr;
   assign cap_wdata    = pick ? m1_wdata : m0_wdata;
   assign wait_cnt_nxt = wait_cnt + 8'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         win        <= 1'b0;
         hold_w     <= 1'b0;
         wait_cnt   <= 8'd0;
         m0_gnt     <= 1'b0;
         m1_gnt     <= 1'b0;
         m0_done    <= 1'b0;
         m1_done    <= 1'b0;
         m0_err     <= 1'b0;
         m1_err     <= 1'b0;
         m0_rdata   <= '0;
         m1_rdata   <= '0;
         bus_wd     <= 1'b0;
         bus_rd     <= 1'b0;
         bus_size   <= 2'd0;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         busy       <= 1'b0;
      end else begin
         m0_done <= 1'b0;
         m1_done <= 1'b0;
         m0_err  <= 1'b0;
         m1_err  <= 1'b0;
         bus_wd  <= 1'b0;
         bus_rd  <= 1'b0;
         case (state)
            IDLE: begin
               if ((m0_req || m1_req) && bus_ready) begin
                  win       <= pick;
                  hold_w    <= cap_w;
                  bus_size  <= cap_size;
                  bus_addr  <= cap_addr;
                  bus_wdata <= cap_wdata;
                  bus_wd    <= cap_w;
                  bus_rd    <= ~cap_w;
                  m0_gnt    <= ~pick;
                  m1_gnt    <= pick;
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            // Done and err are raised on the way into DONE so they are visible during it.
            WAIT: begin
               if (!bus_busy) begin
                  if (!hold_w) begin
                     if (win) m1_rdata <= bus_rdata;
                     else     m0_rdata <= bus_rdata;
                  end
                  m0_done    <= ~win;
                  m1_done    <= win;
                  last_grant <= win;
                  state      <= DONE;
               end else begin
                  wait_cnt <= wait_cnt_nxt;
                  if (wait_cnt_nxt == TIMEOUT_CNT) begin
                     m0_done    <= ~win;
                     m1_done    <= win;
                     m0_err     <= ~win;
                     m1_err     <= win;
                     last_grant <= win;
                     state      <= DONE;
                  end
               end
            end
            DONE: begin
               wait_cnt  <= 8'd0;
               m0_gnt    <= 1'b0;
               m1_gnt    <= 1'b0;
               busy      <= 1'b0;
               bus_size  <= 2'd0;
               bus_addr  <= '0;
               bus_wdata <= '0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: per-cycle stimulus tables checked against a
// transaction-timeline model, plus a directed reset-during-wait sequence.
module tb_data_bus_arbiter;

   localparam int TO = 8;
   localparam int L  = 320;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_w, m1_req, m1_w;
   logic [1:0]  m0_size, m1_size;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        bus_wd, bus_rd, bus_ready, bus_busy, busy;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;

   int n_compared   = 0;
   int n_mismatched = 0;

   logic        s_req   [0:1][0:L-1];
   logic        s_w     [0:1][0:L-1];
   logic [1:0]  s_size  [0:1][0:L-1];
   logic [31:0] s_addr  [0:1][0:L-1];
   logic [31:0] s_wdata [0:1][0:L-1];
   logic        s_ready [0:L-1];
   logic        s_busy  [0:L-1];
   logic [31:0] s_rdata [0:L-1];

   logic        e_gnt   [0:1][0:L-1];
   logic        e_done  [0:1][0:L-1];
   logic        e_err   [0:1][0:L-1];
   logic [31:0] e_rdata [0:1][0:L-1];
   logic        e_wd    [0:L-1];
   logic        e_rd    [0:L-1];
   logic        e_busy  [0:L-1];
   logic [1:0]  e_size  [0:L-1];
   logic [31:0] e_addr  [0:L-1];
   logic [31:0] e_wdata [0:L-1];

   data_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_w(m0_w), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_w(m1_w), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .bus_wd(bus_wd), .bus_rd(bus_rd), .bus_size(bus_size), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
      .bus_busy(bus_busy), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_compared++;
      assert (observed === expected) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic clearStimulus();
      for (int c = 0; c < L; c++) begin
         for (int k = 0; k < 2; k++) begin
            s_req[k][c] = 1'b0; s_w[k][c] = 1'b0; s_size[k][c] = 2'd0;
            s_addr[k][c] = 32'd0; s_wdata[k][c] = 32'd0;
         end
         s_ready[c] = 1'b1; s_busy[c] = 1'b0; s_rdata[c] = 32'd0;
      end
   endtask

   task automatic applyStimulus(input int c);
      m0_req = s_req[0][c]; m0_w = s_w[0][c]; m0_size = s_size[0][c];
      m0_addr = s_addr[0][c]; m0_wdata = s_wdata[0][c];
      m1_req = s_req[1][c]; m1_w = s_w[1][c]; m1_size = s_size[1][c];
      m1_addr = s_addr[1][c]; m1_wdata = s_wdata[1][c];
      bus_ready = s_ready[c]; bus_busy = s_busy[c]; bus_rdata = s_rdata[c];
   endtask

   // Walk the timeline one access at a time: arbitration cycle, strobe cycle,
   // then the first not-busy cycle (or the TO-th busy one) decides completion.
   task automatic buildModel(input int len);
      int t, g, d, c, waits, win;
      logic lg, err, w;
      logic [1:0] sz;
      logic [31:0] a, wd, rv;
      for (int k = 0; k < len; k++) begin
         for (int m = 0; m < 2; m++) begin
            e_gnt[m][k] = 0; e_done[m][k] = 0; e_err[m][k] = 0; e_rdata[m][k] = 0;
         end
         e_wd[k] = 0; e_rd[k] = 0; e_busy[k] = 0; e_size[k] = 0; e_addr[k] = 0; e_wdata[k] = 0;
      end
      lg = 1'b1;
      t = 0;
      while (t < len) begin
         if ((s_req[0][t] || s_req[1][t]) && s_ready[t]) begin
            if (s_req[0][t] && s_req[1][t]) win = lg ? 0 : 1;
            else                            win = s_req[1][t] ? 1 : 0;
            w = s_w[win][t]; sz = s_size[win][t]; a = s_addr[win][t]; wd = s_wdata[win][t];
            g = t + 1; c = g + 1; waits = 0; err = 0; d = len + 10; rv = 0;
            while (c < len) begin
               if (!s_busy[c]) begin d = c + 1; rv = s_rdata[c]; break; end
               waits++;
               if (waits == TO) begin d = c + 1; err = 1; break; end
               c++;
            end
            for (int k = g; k <= d && k < len; k++) begin
               e_gnt[win][k] = 1; e_busy[k] = 1; e_addr[k] = a; e_size[k] = sz; e_wdata[k] = wd;
            end
            if (g < len) begin e_wd[g] = w; e_rd[g] = !w; end
            if (d < len) begin
               e_done[win][d] = 1; e_err[win][d] = err;
               if (!w && !err) for (int k = d; k < len; k++) e_rdata[win][k] = rv;
            end
            lg = win[0];
            t = d + 1;
         end else begin
            t++;
         end
      end
   endtask

   task automatic doReset();
      clearStimulus();
      applyStimulus(0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset gnt", {m0_gnt, m1_gnt}, 0);
      checkOutput("reset done_err", {m0_done, m1_done, m0_err, m1_err}, 0);
      checkOutput("reset strobes_busy", {bus_wd, bus_rd, busy}, 0);
      checkOutput("reset bus_addr", bus_addr, 0);
      checkOutput("reset bus_wdata", bus_wdata, 0);
      checkOutput("reset bus_size", bus_size, 0);
      checkOutput("reset m0_rdata", m0_rdata, 0);
      checkOutput("reset m1_rdata", m1_rdata, 0);
   endtask

   task automatic runScenario(input string name, input int len);
      // Stimulus tables are filled by the caller; reset clears them, so keep a copy.
      logic        k_req [0:1][0:L-1];
      logic        k_w   [0:1][0:L-1];
      logic [1:0]  k_sz  [0:1][0:L-1];
      logic [31:0] k_ad  [0:1][0:L-1];
      logic [31:0] k_wd  [0:1][0:L-1];
      logic        k_rdy [0:L-1];
      logic        k_bsy [0:L-1];
      logic [31:0] k_rd  [0:L-1];
      k_req = s_req; k_w = s_w; k_sz = s_size; k_ad = s_addr; k_wd = s_wdata;
      k_rdy = s_ready; k_bsy = s_busy; k_rd = s_rdata;
      doReset();
      s_req = k_req; s_w = k_w; s_size = k_sz; s_addr = k_ad; s_wdata = k_wd;
      s_ready = k_rdy; s_busy = k_bsy; s_rdata = k_rd;
      buildModel(len);
      for (int c = 0; c < len; c++) begin
         applyStimulus(c);
         @(negedge clk);
         checkOutput($sformatf("%s c%0d m0_gnt", name, c), m0_gnt, e_gnt[0][c]);
         checkOutput($sformatf("%s c%0d m1_gnt", name, c), m1_gnt, e_gnt[1][c]);
         checkOutput($sformatf("%s c%0d m0_done", name, c), m0_done, e_done[0][c]);
         checkOutput($sformatf("%s c%0d m1_done", name, c), m1_done, e_done[1][c]);
         checkOutput($sformatf("%s c%0d m0_err", name, c), m0_err, e_err[0][c]);
         checkOutput($sformatf("%s c%0d m1_err", name, c), m1_err, e_err[1][c]);
         checkOutput($sformatf("%s c%0d bus_wd", name, c), bus_wd, e_wd[c]);
         checkOutput($sformatf("%s c%0d bus_rd", name, c), bus_rd, e_rd[c]);
         checkOutput($sformatf("%s c%0d busy", name, c), busy, e_busy[c]);
         checkOutput($sformatf("%s c%0d bus_addr", name, c), bus_addr, e_addr[c]);
         checkOutput($sformatf("%s c%0d bus_size", name, c), bus_size, e_size[c]);
         checkOutput($sformatf("%s c%0d bus_wdata", name, c), bus_wdata, e_wdata[c]);
         checkOutput($sformatf("%s c%0d m0_rdata", name, c), m0_rdata, e_rdata[0][c]);
         checkOutput($sformatf("%s c%0d m1_rdata", name, c), m1_rdata, e_rdata[1][c]);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      clearStimulus();
      applyStimulus(0);

      // Single read with an immediately free bus.
      clearStimulus();
      for (int c = 0; c < 10; c++) s_rdata[c] = 32'hDEADBEEF;
      s_req[0][2] = 1; s_addr[0][2] = 32'h100; s_size[0][2] = 2'd2;
      runScenario("single_read", 10);

      // Both requesters held: alternating grants starting with m0.
      clearStimulus();
      for (int c = 0; c < 14; c++) begin
         s_req[0][c] = 1; s_req[1][c] = 1; s_addr[0][c] = 32'h10; s_addr[1][c] = 32'h20;
         s_rdata[c] = 32'hA0 + c;
      end
      runScenario("tie", 14);

      // m1 read, then m1 write stretched by wait states; write leaves rdata alone.
      clearStimulus();
      for (int c = 0; c < 16; c++) s_rdata[c] = (c < 6) ? 32'hCAFEF00D : 32'h55555555;
      s_req[1][1] = 1; s_addr[1][1] = 32'h80;
      s_req[1][5] = 1; s_w[1][5] = 1; s_addr[1][5] = 32'h40; s_wdata[1][5] = 32'h12345678;
      s_size[1][5] = 2'd2;
      for (int c = 6; c < 10; c++) s_busy[c] = 1;
      runScenario("wait_states", 16);

      // Bus never frees: abort after TO wait cycles with err.
      clearStimulus();
      for (int c = 0; c < 16; c++) begin s_busy[c] = 1; s_rdata[c] = 32'h11111111; end
      for (int c = 0; c < 4; c++) begin s_req[0][c] = 1; s_addr[0][c] = 32'h300; end
      runScenario("timeout", 16);

      // Requests pending while the bus is not ready.
      clearStimulus();
      for (int c = 0; c < 12; c++) begin
         s_req[0][c] = 1; s_w[0][c] = 1; s_addr[0][c] = 32'h500; s_wdata[0][c] = 32'hBEEF0000 + c;
         s_ready[c] = (c >= 5);
      end
      runScenario("not_ready", 12);

      // Randomised traffic.
      clearStimulus();
      for (int c = 0; c < 300; c++) begin
         for (int k = 0; k < 2; k++) begin
            s_req[k][c] = ($urandom_range(0, 99) < 40);
            s_w[k][c] = $urandom_range(0, 1) == 1;
            s_size[k][c] = 2'($urandom_range(0, 2));
            s_addr[k][c] = $urandom;
            s_wdata[k][c] = $urandom;
         end
         s_ready[c] = ($urandom_range(0, 99) < 80);
         s_busy[c] = ($urandom_range(0, 99) < 70);
         s_rdata[c] = $urandom;
      end
      runScenario("random", 300);

      // Reset in the middle of a wait: no completion, and m0 wins the next tie.
      doReset();
      m0_req = 1; m0_w = 0; m0_addr = 32'h200; bus_ready = 1; bus_busy = 1;
      stepCycle();
      m0_req = 0;
      stepCycle();
      stepCycle();
      checkOutput("rstwait in_wait gnt", {m0_gnt, m1_gnt, busy}, 3'b101);
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      checkOutput("rstwait gnt", {m0_gnt, m1_gnt}, 0);
      checkOutput("rstwait done_err", {m0_done, m1_done, m0_err, m1_err}, 0);
      checkOutput("rstwait busy", busy, 0);
      m0_req = 1; m1_req = 1; bus_busy = 0;
      stepCycle();
      m0_req = 0; m1_req = 0;
      checkOutput("rstwait tie gnt", {m0_gnt, m1_gnt}, 2'b10);
      stepCycle();
      stepCycle();
      checkOutput("rstwait tie done", {m0_done, m1_done, m0_err}, 3'b100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
